// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS-subset CPU datapath.
// Holds PC, IR, MDR and ALUOut, a 32x32 register file and an 8-operation ALU.
// An external control FSM drives every select and enable, one cycle at a time.
// Optional feature macro: DP_OVERFLOW_EN enables signed add/sub overflow
// detection; when it is undefined, overflow is tied low and its logic is absent.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [1:0]  RegDst,
  input  logic        RegWrite,
  input  logic [1:0]  MemtoReg,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSource,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        Branch,
  input  logic [2:0]  ALU_operation,
  input  logic [31:0] data2CPU,
  output logic [31:0] PC_Current,
  output logic [31:0] Inst,
  output logic [31:0] data_out,
  output logic [31:0] M_addr,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;
  logic [31:0] alu_out_q;
  logic [31:0] reg_file [32];

  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  shamt;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic [31:0] imm_sext;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [31:0] pc_in;
  logic        pc_en;

  assign rs_addr  = ir_q[25:21];
  assign rt_addr  = ir_q[20:16];
  assign shamt    = ir_q[10:6];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  // Asynchronous register-file reads; $0 is hard-wired to zero.
  assign rdata_a = (rs_addr == 5'd0) ? 32'd0 : reg_file[rs_addr];
  assign rdata_b = (rt_addr == 5'd0) ? 32'd0 : reg_file[rt_addr];

  // ALU operand A selects between the PC (fetch/branch target) and rs.
  always_comb begin
    alu_a = ALUSrcA ? rdata_a : pc_q;
  end

  // ALU operand B: rt, constant 4, sign-extended immediate, or word offset.
  always_comb begin
    alu_b = rdata_b;
    case (ALUSrcB)
      2'b00:   alu_b = rdata_b;
      2'b01:   alu_b = 32'd4;
      2'b10:   alu_b = imm_sext;
      default: alu_b = {imm_sext[29:0], 2'b00};
    endcase
  end

  // Eight-function ALU; srl takes its shift amount from the shamt field and
  // slt is an unsigned compare.
  always_comb begin
    alu_res = 32'd0;
    case (ALU_operation)
      3'b000:  alu_res = alu_a & alu_b;
      3'b001:  alu_res = alu_a | alu_b;
      3'b010:  alu_res = alu_a + alu_b;
      3'b011:  alu_res = alu_a ^ alu_b;
      3'b100:  alu_res = ~(alu_a | alu_b);
      3'b101:  alu_res = alu_b >> shamt;
      3'b110:  alu_res = alu_a - alu_b;
      default: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
    endcase
  end

  assign zero = (alu_res == 32'd0);

`ifdef DP_OVERFLOW_EN
  // Signed overflow: add overflows when like-signed operands give an
  // opposite-signed result; sub when unlike-signed operands do.
  always_comb begin
    overflow = 1'b0;
    case (ALU_operation)
      3'b010:  overflow = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
      3'b110:  overflow = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
      default: overflow = 1'b0;
    endcase
  end
`else
  assign overflow = 1'b0;
`endif

  // Destination register: rt for I-type, rd for R-type, $31 for link.
  always_comb begin
    wreg = rt_addr;
    case (RegDst)
      2'b00:   wreg = rt_addr;
      2'b01:   wreg = ir_q[15:11];
      default: wreg = 5'd31;
    endcase
  end

  // Write-back data: ALUOut, loaded word, lui value, or this cycle's ALU result.
  always_comb begin
    wdata = alu_out_q;
    case (MemtoReg)
      2'b00:   wdata = alu_out_q;
      2'b01:   wdata = mdr_q;
      2'b10:   wdata = {ir_q[15:0], 16'h0000};
      default: wdata = alu_res;
    endcase
  end

  // Next PC: incremented PC, branch target, jump target, or jr register.
  always_comb begin
    pc_in = alu_res;
    case (PCSource)
      2'b00:   pc_in = alu_res;
      2'b01:   pc_in = alu_out_q;
      2'b10:   pc_in = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: pc_in = rdata_a;
    endcase
  end

  // PC updates only when memory is ready, on an unconditional write or a
  // taken branch (beq takes on zero, bne on non-zero).
  assign pc_en = MIO_ready & (PCWrite | (PCWriteCond & ~(Branch ^ zero)));

  // PC and IR: loaded under their enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      ir_q <= 32'd0;
    end else begin
      if (pc_en)   pc_q <= pc_in;
      if (IRWrite) ir_q <= data2CPU;
    end
  end

  // MDR and ALUOut capture every cycle so the next state can consume them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdr_q     <= 32'd0;
      alu_out_q <= 32'd0;
    end else begin
      mdr_q     <= data2CPU;
      alu_out_q <= alu_res;
    end
  end

  // Register file write port; writes to $0 are discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) reg_file[i] <= 32'd0;
    end else if (RegWrite && (wreg != 5'd0)) begin
      reg_file[wreg] <= wdata;
    end
  end

  assign PC_Current = pc_q;
  assign Inst       = ir_q;
  assign data_out   = rdata_b;
  assign M_addr     = IorD ? alu_out_q : pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed instruction sequences for mc_datapath with a
// scoreboard queue of expected outputs checked at each falling clock edge.
module tb_mc_datapath;

  localparam int SEL_PC   = 0;
  localparam int SEL_INST = 1;
  localparam int SEL_DOUT = 2;
  localparam int SEL_ADDR = 3;
  localparam int SEL_ZERO = 4;
  localparam int SEL_OVF  = 5;

`ifdef DP_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  // Expected ALU results for A=32'h7FFF_FFFF, B=sext(16'hFF81), shamt=30,
  // indexed by ALU_operation.
  localparam logic [31:0] ALU_EXP [8] = '{
    32'h7FFF_FF81, 32'hFFFF_FFFF, 32'h7FFF_FF80, 32'h8000_007E,
    32'h0000_0000, 32'h0000_0003, 32'h8000_007E, 32'h0000_0001
  };

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MIO_ready;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [2:0]  ALU_operation;
  logic [31:0] data2CPU;
  logic [31:0] PC_Current;
  logic [31:0] Inst;
  logic [31:0] data_out;
  logic [31:0] M_addr;
  logic        zero;
  logic        overflow;

  sb_entry_t sbQueue [$];
  int nChecks = 0;
  int nFails  = 0;

  mc_datapath dut (
    .clk           (clk),
    .reset         (reset),
    .MIO_ready     (MIO_ready),
    .IorD          (IorD),
    .IRWrite       (IRWrite),
    .RegDst        (RegDst),
    .RegWrite      (RegWrite),
    .MemtoReg      (MemtoReg),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .PCSource      (PCSource),
    .PCWrite       (PCWrite),
    .PCWriteCond   (PCWriteCond),
    .Branch        (Branch),
    .ALU_operation (ALU_operation),
    .data2CPU      (data2CPU),
    .PC_Current    (PC_Current),
    .Inst          (Inst),
    .data_out      (data_out),
    .M_addr        (M_addr),
    .zero          (zero),
    .overflow      (overflow)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] getActual(input int sel);
    case (sel)
      SEL_PC:   return PC_Current;
      SEL_INST: return Inst;
      SEL_DOUT: return data_out;
      SEL_ADDR: return M_addr;
      SEL_ZERO: return {31'd0, zero};
      default:  return {31'd0, overflow};
    endcase
  endfunction

  // Monitor: every falling edge, compare the DUT against all queued expectations.
  initial begin
    sb_entry_t   e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sbQueue.size() > 0) begin
        e   = sbQueue.pop_front();
        act = getActual(e.sel);
        nChecks++;
        if (act !== e.exp) begin
          nFails++;
          $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic checkOutput(input int sel, input logic [31:0] exp, input string name);
    sb_entry_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sbQueue.push_back(e);
  endtask

  task automatic setIdle();
    MIO_ready     = 1'b1;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    MemtoReg      = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ALU_operation = 3'b000;
    data2CPU      = 32'd0;
  endtask

  // Hold the driven inputs through one falling edge (checks) and one rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  // Instruction fetch: IR <= word, PC <= PC + 4.
  task automatic fetch(input logic [31:0] word, input logic [31:0] pcNow);
    setIdle();
    IRWrite       = 1'b1;
    ALUSrcB       = 2'b01;
    ALU_operation = 3'b010;
    PCWrite       = 1'b1;
    data2CPU      = word;
    checkOutput(SEL_ADDR, pcNow, "fetch_addr");
    applyStimulus();
    checkOutput(SEL_INST, word, "fetch_ir");
    checkOutput(SEL_PC, pcNow + 32'd4, "fetch_pc");
  endtask

  initial begin
    setIdle();
    #2 reset = 1'b0;
    checkOutput(SEL_PC, 32'd0, "reset_pc");
    checkOutput(SEL_INST, 32'd0, "reset_ir");
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // addi $8,$0,5
    fetch(32'h2008_0005, 32'h0);
    setIdle(); ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = 3'b010;
    checkOutput(SEL_ZERO, 32'd0, "addi_zero");
    applyStimulus();
    setIdle(); RegWrite = 1'b1; IorD = 1'b1;
    checkOutput(SEL_ADDR, 32'd5, "aluout_addr");
    checkOutput(SEL_DOUT, 32'd0, "r8_before_wr");
    applyStimulus();
    checkOutput(SEL_DOUT, 32'd5, "r8_after_wr");

    // addi $0,$0,7 must leave $0 at zero
    fetch(32'h2000_0007, 32'h4);
    setIdle(); ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = 3'b010;
    applyStimulus();
    setIdle(); RegWrite = 1'b1;
    applyStimulus();
    checkOutput(SEL_DOUT, 32'd0, "r0_stays_zero");

    // lui $9,0xABCD then $9 <= MDR
    fetch(32'h3C09_ABCD, 32'h8);
    setIdle(); RegWrite = 1'b1; MemtoReg = 2'b10;
    applyStimulus();
    checkOutput(SEL_DOUT, 32'hABCD_0000, "lui_r9");
    setIdle(); data2CPU = 32'hDEAD_BEEF;
    applyStimulus();
    setIdle(); RegWrite = 1'b1; MemtoReg = 2'b01;
    applyStimulus();
    checkOutput(SEL_DOUT, 32'hDEAD_BEEF, "mdr_r9");

    // beq $8,$8,+3 : target 16 + 12 = 28
    fetch(32'h1108_0003, 32'hC);
    setIdle(); ALUSrcB = 2'b11; ALU_operation = 3'b010;
    applyStimulus();
    setIdle(); ALUSrcA = 1'b1; ALU_operation = 3'b110;
    PCWriteCond = 1'b1; Branch = 1'b1; PCSource = 2'b01;
    checkOutput(SEL_ZERO, 32'd1, "beq_zero");
    applyStimulus();
    checkOutput(SEL_PC, 32'd28, "beq_taken");
    setIdle(); ALUSrcA = 1'b1; ALU_operation = 3'b110;
    PCWriteCond = 1'b1; Branch = 1'b0; PCSource = 2'b01;
    applyStimulus();
    checkOutput(SEL_PC, 32'd28, "bne_not_taken");
    // $8 - 4 = 1: bne taken to res, then beq not taken
    setIdle(); ALUSrcA = 1'b1; ALUSrcB = 2'b01; ALU_operation = 3'b110;
    PCWriteCond = 1'b1; Branch = 1'b0;
    checkOutput(SEL_ZERO, 32'd0, "bne_zero");
    applyStimulus();
    checkOutput(SEL_PC, 32'd1, "bne_taken");
    setIdle(); ALUSrcA = 1'b1; ALUSrcB = 2'b01; ALU_operation = 3'b110;
    PCWriteCond = 1'b1; Branch = 1'b1;
    applyStimulus();
    checkOutput(SEL_PC, 32'd1, "beq_not_taken");

    // Memory not ready blocks the PC write
    setIdle(); MIO_ready = 1'b0; PCWrite = 1'b1; ALUSrcB = 2'b01; ALU_operation = 3'b010;
    applyStimulus();
    checkOutput(SEL_PC, 32'd1, "mio_stall_pc");

    // jr $9, then j 0x10 keeps PC[31:28]
    fetch(32'h0120_0008, 32'h1);
    setIdle(); PCWrite = 1'b1; PCSource = 2'b11;
    applyStimulus();
    checkOutput(SEL_PC, 32'hDEAD_BEEF, "jr_pc");
    fetch(32'h0800_0010, 32'hDEAD_BEEF);
    setIdle(); PCWrite = 1'b1; PCSource = 2'b10;
    applyStimulus();
    checkOutput(SEL_PC, 32'hD000_0040, "jump_pc");

    // $10 <= 32'h7FFF_FFFF via MDR; IR = rs=rt=10, imm=16'hFF81
    fetch(32'h014A_FF81, 32'hD000_0040);
    setIdle(); data2CPU = 32'h7FFF_FFFF;
    applyStimulus();
    setIdle(); RegWrite = 1'b1; MemtoReg = 2'b01;
    applyStimulus();
    checkOutput(SEL_DOUT, 32'h7FFF_FFFF, "mdr_r10");

    // Sweep all ALU operations; each result is seen on M_addr via ALUOut
    for (int i = 0; i < 8; i++) begin
      setIdle(); ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = i[2:0]; IorD = 1'b1;
      if (i > 0) checkOutput(SEL_ADDR, ALU_EXP[i-1], $sformatf("alu_op%0d", i - 1));
      checkOutput(SEL_ZERO, {31'd0, ALU_EXP[i] == 32'd0}, $sformatf("alu_zero%0d", i));
      if (i == 2) checkOutput(SEL_OVF, 32'd0, "add_no_ovf");
      if (i == 6) checkOutput(SEL_OVF, {31'd0, OVF_ON}, "sub_ovf");
      applyStimulus();
    end
    setIdle(); ALUSrcA = 1'b1; ALUSrcB = 2'b01; ALU_operation = 3'b010; IorD = 1'b1;
    checkOutput(SEL_ADDR, ALU_EXP[7], "alu_op7");
    checkOutput(SEL_OVF, {31'd0, OVF_ON}, "add_ovf");
    checkOutput(SEL_ZERO, 32'd0, "add_ovf_zero");
    applyStimulus();
    setIdle(); ALUSrcA = 1'b1; ALU_operation = 3'b110; IorD = 1'b1;
    checkOutput(SEL_ADDR, 32'h8000_0003, "add_ovf_res");
    checkOutput(SEL_ZERO, 32'd1, "sub_eq_zero");
    checkOutput(SEL_OVF, 32'd0, "sub_eq_ovf");
    applyStimulus();

    // Mid-run asynchronous reset, checked before any rising edge
    setIdle();
    reset = 1'b0;
    checkOutput(SEL_PC, 32'd0, "midreset_pc");
    checkOutput(SEL_INST, 32'd0, "midreset_ir");
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(SEL_PC, 32'd0, "post_reset_hold");
    setIdle(); IRWrite = 1'b1; data2CPU = 32'h014A_0000;
    applyStimulus();
    checkOutput(SEL_INST, 32'h014A_0000, "post_reset_ir");
    checkOutput(SEL_DOUT, 32'd0, "regfile_cleared");
    checkOutput(SEL_PC, 32'd0, "post_reset_pc");
    setIdle(); PCWrite = 1'b1; ALUSrcB = 2'b01; ALU_operation = 3'b010;
    applyStimulus();
    checkOutput(SEL_PC, 32'd4, "post_reset_write");
    setIdle();

    // Let the monitor drain, with a bound
    for (int k = 0; k < 4 && sbQueue.size() > 0; k++) @(negedge clk);
    #1;
    if (sbQueue.size() > 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sbQueue.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
